// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// FSM states, opcode/funct values and ALU operation codes.
package mc_control_unit_pkg;

    // FSM state encoding
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BEQ     = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Operand-B and next-PC selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BR     = 2'b01;
    localparam logic [1:0] PC_JMP    = 2'b10;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// Funct-to-ALU operation decode for R-type instructions.
// Unknown funct codes fall back to add and raise illegal_o.
module alu_decoder
    import mc_control_unit_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);

    // Pure lookup; add is the safe default for unsupported functs
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        illegal_o  = 1'b0;
        case (funct_i)
            F_ADD:   alu_ctrl_o = ALU_ADD;
            F_SUB:   alu_ctrl_o = ALU_SUB;
            F_AND:   alu_ctrl_o = ALU_AND;
            F_OR:    alu_ctrl_o = ALU_OR;
            F_SLT:   alu_ctrl_o = ALU_SLT;
            default: illegal_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM, sticky
// illegal flag and retired-instruction counter.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             PCEn,
    output logic             MemReq,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ill_q, ill_d;

    logic       iord_c, irw_c, mw_c, rw_c, rd_c, m2r_c, asa_c;
    logic [1:0] asb_c, pcs_c;
    logic [2:0] alu_c;
    logic       pcen_c, mreq_c;
    logic       retire_c, op_bad_c, fn_bad_c;

    logic [2:0] dec_alu;
    logic       dec_ill;

    alu_decoder u_alu_dec (
        .funct_i    (Funct),
        .alu_ctrl_o (dec_alu),
        .illegal_o  (dec_ill)
    );

    // Next state and per-state datapath controls
    always_comb begin
        state_d  = S_FETCH;
        iord_c   = 1'b0;
        irw_c    = 1'b0;
        mw_c     = 1'b0;
        rw_c     = 1'b0;
        rd_c     = 1'b0;
        m2r_c    = 1'b0;
        asa_c    = 1'b0;
        asb_c    = SRCB_REG;
        pcs_c    = PC_ALU;
        alu_c    = ALU_AND;
        pcen_c   = 1'b0;
        mreq_c   = 1'b0;
        retire_c = 1'b0;
        op_bad_c = 1'b0;
        fn_bad_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                mreq_c  = 1'b1;
                asb_c   = SRCB_FOUR;
                alu_c   = ALU_ADD;
                irw_c   = MemReady;
                pcen_c  = MemReady;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                asb_c = SRCB_BOFS;
                alu_c = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d  = S_FETCH;
                        op_bad_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                asa_c   = 1'b1;
                asb_c   = SRCB_IMM;
                alu_c   = ALU_ADD;
                state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c  = 1'b1;
                mreq_c  = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                m2r_c    = 1'b1;
                rw_c     = 1'b1;
                retire_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c   = 1'b1;
                mreq_c   = 1'b1;
                mw_c     = MemReady;
                retire_c = MemReady;
                state_d  = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                asa_c    = 1'b1;
                alu_c    = dec_alu;
                fn_bad_c = dec_ill;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rd_c     = 1'b1;
                rw_c     = 1'b1;
                retire_c = 1'b1;
            end
            S_BEQ: begin
                asa_c    = 1'b1;
                alu_c    = ALU_SUB;
                pcs_c    = PC_BR;
                pcen_c   = Zero;
                retire_c = 1'b1;
            end
            S_ADDIEX: begin
                asa_c   = 1'b1;
                asb_c   = SRCB_IMM;
                alu_c   = ALU_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rw_c     = 1'b1;
                retire_c = 1'b1;
            end
            S_JUMP: begin
                pcs_c    = PC_JMP;
                pcen_c   = 1'b1;
                retire_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Sticky illegal flag and wrapping retire counter
    always_comb begin
        ill_d = ill_q | op_bad_c | fn_bad_c;
        cnt_d = retire_c ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers; reset abandons any instruction in flight
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    // Write strobes and memory request are held off while in reset
    assign IRWrite    = irw_c & Reset;
    assign PCEn       = pcen_c & Reset;
    assign MemWrite   = mw_c & Reset;
    assign RegWrite   = rw_c & Reset;
    assign MemReq     = mreq_c & Reset;
    assign IorD       = iord_c;
    assign RegDst     = rd_c;
    assign MemtoReg   = m2r_c;
    assign ALUSrcA    = asa_c;
    assign ALUSrcB    = asb_c;
    assign PCSrc      = pcs_c;
    assign ALUControl = alu_c;
    assign Illegal    = ill_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: per-cycle expected
// control words are queued on drive and checked at negedge.
module tb_mc_control_unit;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [5:0]    Op;
    logic [5:0]    Funct;
    logic          Zero;
    logic          MemReady;
    logic          IorD, IRWrite, MemWrite, RegWrite;
    logic          RegDst, MemtoReg, ALUSrcA;
    logic [1:0]    ALUSrcB, PCSrc;
    logic [2:0]    ALUControl;
    logic          PCEn, MemReq, Illegal;
    logic [CW-1:0] InstrCount;

    mc_control_unit #(.CNT_W(CW)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .PCEn       (PCEn),
        .MemReq     (MemReq),
        .Illegal    (Illegal),
        .InstrCount (InstrCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } sb_t;

    sb_t           sbq[$];
    sb_t           cur;
    int            n_chk = 0;
    int            n_pass = 0;
    logic          exp_ill = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", tag, got, want);
    endtask

    // Layout: iord irw mw rw rd m2r asa asb pcs alu pcen mreq
    function automatic logic [15:0] mk(
        input logic a, b, c, d, e, f, g,
        input logic [1:0] sb, pc,
        input logic [2:0] alu,
        input logic pe, mq);
        return {a, b, c, d, e, f, g, sb, pc, alu, pe, mq};
    endfunction

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    function automatic logic [15:0] e_fetch(input logic mr);
        return mk(O, mr, O, O, O, O, O, 2'b01, 2'b00, 3'b010, mr, I);
    endfunction
    function automatic logic [15:0] e_mwr(input logic mr);
        return mk(I, O, mr, O, O, O, O, 2'b00, 2'b00, 3'b000, O, I);
    endfunction
    function automatic logic [15:0] e_ex(input logic [2:0] alu);
        return mk(O, O, O, O, O, O, I, 2'b00, 2'b00, alu, O, O);
    endfunction
    function automatic logic [15:0] e_beq(input logic z);
        return mk(O, O, O, O, O, O, I, 2'b00, 2'b01, 3'b110, z, O);
    endfunction

    logic [15:0] E_DEC, E_MADR, E_MRD, E_MWB, E_AWB;
    logic [15:0] E_AIEX, E_AIWB, E_JMP, E_RST;
    initial begin
        E_DEC  = mk(O, O, O, O, O, O, O, 2'b11, 2'b00, 3'b010, O, O);
        E_MADR = mk(O, O, O, O, O, O, I, 2'b10, 2'b00, 3'b010, O, O);
        E_MRD  = mk(I, O, O, O, O, O, O, 2'b00, 2'b00, 3'b000, O, I);
        E_MWB  = mk(O, O, O, I, O, I, O, 2'b00, 2'b00, 3'b000, O, O);
        E_AWB  = mk(O, O, O, I, I, O, O, 2'b00, 2'b00, 3'b000, O, O);
        E_AIEX = mk(O, O, O, O, O, O, I, 2'b10, 2'b00, 3'b010, O, O);
        E_AIWB = mk(O, O, O, I, O, O, O, 2'b00, 2'b00, 3'b000, O, O);
        E_JMP  = mk(O, O, O, O, O, O, O, 2'b00, 2'b10, 3'b000, I, O);
        E_RST  = mk(O, O, O, O, O, O, O, 2'b01, 2'b00, 3'b010, O, O);
    end

    // Pops the expectation for the current cycle
    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            check(cur.tag,
                  {11'd0, IorD, IRWrite, MemWrite, RegWrite, RegDst,
                   MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
                   PCEn, MemReq, Illegal, InstrCount},
                  {11'd0, cur.v});
        end
    end

    task automatic cyc(input string tag, input logic [15:0] e,
                       input logic mr, input logic z,
                       input logic rst);
        sb_t s;
        Reset    = rst;
        MemReady = mr;
        Zero     = z;
        s.tag = tag;
        s.v   = {e, exp_ill, exp_cnt};
        sbq.push_back(s);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_jump(input string tag);
        Op = 6'b000010;
        cyc({tag, ".fetch"}, e_fetch(I), I, O, I);
        cyc({tag, ".dec"}, E_DEC, I, O, I);
        cyc({tag, ".jump"}, E_JMP, I, O, I);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_rtype(input string tag, input logic [5:0] fn,
                            input logic [2:0] alu, input logic bad);
        Op = 6'b000000;
        Funct = fn;
        cyc({tag, ".fetch"}, e_fetch(I), I, O, I);
        cyc({tag, ".dec"}, E_DEC, O, O, I);
        cyc({tag, ".exec"}, e_ex(alu), I, O, I);
        if (bad) exp_ill = 1'b1;
        cyc({tag, ".aluwb"}, E_AWB, O, O, I);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        MemReady = 1'b1;
        Zero = 1'b0;
        Op = 6'd0;
        Funct = 6'd0;
        @(posedge CLK);
        #1;
        cyc("rst.a", E_RST, I, I, O);
        cyc("rst.b", E_RST, I, I, O);

        // lw, memory always ready
        Op = 6'b100011;
        cyc("lw.fetch", e_fetch(I), I, O, I);
        cyc("lw.dec", E_DEC, I, O, I);
        cyc("lw.madr", E_MADR, I, O, I);
        cyc("lw.mrd", E_MRD, I, O, I);
        cyc("lw.mwb", E_MWB, I, O, I);
        exp_cnt = exp_cnt + 1'b1;

        // sw with a fetch stall and a 3-cycle write stall
        Op = 6'b101011;
        cyc("sw.fstall", e_fetch(O), O, O, I);
        cyc("sw.fetch", e_fetch(I), I, O, I);
        cyc("sw.dec", E_DEC, I, O, I);
        cyc("sw.madr", E_MADR, I, O, I);
        for (int k = 0; k < 3; k++)
            cyc("sw.mwr_wait", e_mwr(O), O, O, I);
        cyc("sw.mwr_go", e_mwr(I), I, O, I);
        exp_cnt = exp_cnt + 1'b1;

        // beq taken then not taken
        Op = 6'b000100;
        cyc("beq1.fetch", e_fetch(I), I, O, I);
        cyc("beq1.dec", E_DEC, I, I, I);
        cyc("beq1.beq", e_beq(I), I, I, I);
        exp_cnt = exp_cnt + 1'b1;
        cyc("beq0.fetch", e_fetch(I), I, O, I);
        cyc("beq0.dec", E_DEC, I, O, I);
        cyc("beq0.beq", e_beq(O), I, O, I);
        exp_cnt = exp_cnt + 1'b1;

        do_rtype("slt", 6'b101010, 3'b111, O);
        do_rtype("sub", 6'b100010, 3'b110, O);

        // addi
        Op = 6'b001000;
        cyc("addi.fetch", e_fetch(I), I, O, I);
        cyc("addi.dec", E_DEC, I, O, I);
        cyc("addi.ex", E_AIEX, I, O, I);
        cyc("addi.wb", E_AIWB, I, O, I);
        exp_cnt = exp_cnt + 1'b1;

        do_jump("j");
        do_rtype("badfn", 6'b111111, 3'b010, I);

        // reset in the middle of a stalled load
        Op = 6'b100011;
        cyc("lwr.fetch", e_fetch(I), I, O, I);
        cyc("lwr.dec", E_DEC, I, O, I);
        cyc("lwr.madr", E_MADR, I, O, I);
        cyc("lwr.mrd", E_MRD, O, O, I);
        exp_cnt = '0;
        exp_ill = 1'b0;
        cyc("lwr.rst", E_RST, I, I, O);
        cyc("lwr.hold", E_RST, I, I, O);

        // unsupported opcode: back to fetch, no retire
        Op = 6'b111111;
        cyc("ill.fetch", e_fetch(I), I, O, I);
        cyc("ill.dec", E_DEC, I, O, I);
        exp_ill = 1'b1;
        cyc("ill.after", e_fetch(O), O, O, I);

        // counter wrap
        for (int k = 0; k < (1 << CW); k++)
            do_jump("wrap");
        cyc("wrap.end", e_fetch(O), O, O, I);

        if (sbq.size() != 0) check("sb.drain", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Port: CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: Reset  in  1  asynchronous, active-low reset.
REQ-004 Port: Op  in  6  Instr[31:26] from the instruction register.
REQ-005 Port: Funct  in  6  Instr[5:0] from the instruction register.
REQ-006 Port: Zero  in  1  ALU zero flag.
REQ-007 Port: MemReady  in  1  unified memory completes the current access this cycle.
REQ-008 Port: IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  multicycle datapath controls.
REQ-009 Port: ALUSrcB, PCSrc  out  2 each  operand-B select and next-PC select.
REQ-010 Port: ALUControl  out  3  ALU operation code.
REQ-011 Port: PCEn  out  1  PC register write enable.
REQ-012 Port: MemReq  out  1  memory access request.
REQ-013 Port: Illegal  out  1  sticky unsupported-opcode flag.
REQ-014 Port: InstrCount  out  CNT_W  count of retired instructions.

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP; the FSM is Moore, and the only exceptions are the strobes gated by MemReady and Zero.
REQ-016 FETCH: IorD=0, MemReq=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=PCEn=MemReady; stays in FETCH while MemReady=0, else goes to DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010; next state by Op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with Illegal set.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010; goes to MEMRD for Op 100011, else MEMWR.
REQ-019 MEMRD: IorD=1, MemReq=1; held until MemReady, then goes to MEMWB.
REQ-020 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then goes to FETCH.
REQ-021 MEMWR: IorD=1, MemReq=1, MemWrite=MemReady; held until MemReady, then goes to FETCH.
REQ-022 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct (100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010 with Illegal set); then goes to ALUWB.
REQ-023 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; then goes to FETCH.
REQ-024 BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, PCEn=Zero; then goes to FETCH.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010 -> ADDIWB; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-026 JUMP: PCSrc=10, PCEn=1; then goes to FETCH.
REQ-027 Any output not listed for a state is 0 in that state.
REQ-028 InstrCount increments by 1 on the final cycle of each instruction: MEMWB, MEMWR with MemReady, ALUWB, BEQ, ADDIWB, JUMP.
REQ-029 InstrCount wraps modulo 2^CNT_W; an illegal-opcode DECODE does not increment it.
REQ-030 Illegal stays 1 until reset; only reset clears it.
REQ-031 MemReady is ignored in all states except FETCH, MEMRD and MEMWR.

Reset
REQ-032 Reset=0 immediately forces state=FETCH, InstrCount=0, Illegal=0.
REQ-033 While Reset=0, IRWrite, PCEn, MemWrite, RegWrite and MemReq are all forced to 0.
REQ-034 On reset release, the first rising edge of CLK evaluates FETCH normally.
REQ-035 Reset asserted mid-instruction abandons that instruction; no further write strobe is issued for it.

Structure
REQ-036 A shared package holds the state encoding, opcode constants, funct constants and ALUControl codes.
REQ-037 The Funct-to-ALUControl decode lives in one combinational sub-module, alu_decoder; the FSM and counters stay in mc_control_unit.

Verification
REQ-038 lw (Op=100011), MemReady=1 in every memory state -> FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; RegWrite=1 with MemtoReg=1 in MEMWB; InstrCount 0->1.
REQ-039 sw with MemReady low for 3 cycles in MEMWR -> MemWrite stays 0 for those 3 cycles, is 1 for exactly one cycle, then returns to FETCH.
REQ-040 beq with Zero=1, then beq with Zero=0 -> PCEn=1 with PCSrc=01 in BEQ for the first, PCEn=0 for the second; InstrCount +2.
REQ-041 R-type Funct=101010 -> ALUControl=111 in EXECUTE, RegDst=1 in ALUWB; Funct=111111 -> ALUControl=010 and Illegal=1.
REQ-042 Op=111111 -> DECODE returns to FETCH, Illegal=1, no RegWrite, InstrCount unchanged.
REQ-043 Reset asserted during MEMRD, and InstrCount preset near max then one more instruction -> state=FETCH, all strobes 0, Illegal=0; counter wraps 2^CNT_W-1 -> 0.
